clk_div_prog: RTL
=================

Name: clk_div_prog

Overview:
- Runtime-programmable, parametrised successor to the fixed VFD clock divider.
- Generates a 50%-duty clk_out whose period is 2*(TC+1) clk_in cycles; TC is loadable at runtime.
- New divisor values take effect glitch-free, only at full-period boundaries.
- Adds run/stop control with no runt pulses, and a one-cycle tick strobe per output period for the VFD modulation/timing logic downstream.

Parameters:
- CNT_W, 16, width of counter and terminal-count registers.
- DEFAULT_TC, 294, terminal count in effect after reset (period 590 clk_in cycles).

Ports:
- clk_in  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  run request; level-sensitive
- tc_load  input  1  one-cycle strobe; captures tc_value
- tc_value  input  CNT_W  new terminal count (half-period minus 1)
- clk_out  output  1  divided clock, registered
- tick  output  1  one-cycle pulse in the cycle clk_out rises
- tc_active  output  CNT_W  terminal count currently in use
- upd_pending  output  1  loaded value waiting for a period boundary
- running  output  1  high in RUN or STOPPING

Behaviour:
- All logic on posedge clk_in. Reset is synchronous and active-high, and overrides everything.
- Reset values:
  - counter=0, clk_out=0, tick=0, tc_active=DEFAULT_TC
  - pending reg=0, upd_pending=0, running=0
  - state=IDLE
- States are IDLE, RUN and STOPPING.
- IDLE:
  - Counter is held at 0 and clk_out=0.
  - enable=1 -> RUN next cycle. Counter counts from 0 with clk_out low for the first half-period.
- RUN:
  - Counter increments each cycle.
  - When counter==tc_active, the counter wraps to 0 and clk_out toggles.
  - On a 0->1 toggle, tick=1 in the same cycle clk_out goes high (both registered).
  - A half-period is always exactly tc_active+1 cycles. TC=0 gives clk_out toggling every cycle (period 2).
- Period boundary: the cycle where counter==tc_active and clk_out==1, i.e. clk_out falls.
- TC update:
  - tc_load captures tc_value into the pending reg and sets upd_pending.
  - If several loads arrive before a boundary, the latest one wins.
  - At a boundary with upd_pending=1, tc_active takes the pending value and upd_pending clears. The next half-period uses the new value.
  - If tc_load coincides with a boundary, the boundary uses the previously pending value (if any). The new value stays pending for the following boundary.
  - tc_load in IDLE: tc_active updates on the next cycle and upd_pending stays 0.
- enable deasserted in RUN:
  - If clk_out=0: go to IDLE next cycle. Counter clears; clk_out stays 0.
  - If clk_out=1: go to STOPPING. The high half-period completes at full length, then at the boundary clk_out=0 and state goes to IDLE. Any pending TC is applied at this boundary.
- enable reasserted in STOPPING: return to RUN. Counting continues uninterrupted, so there is no phase disturbance.
- Width/arithmetic: the counter is unsigned CNT_W and compares by equality only. tc_value may be any value from 0 to 2^CNT_W-1; no saturation is needed.
- Reset mid-operation (any state): all outputs return to their reset values in the next cycle. A pending update is discarded.

Decomposition:
- Shared package vfd_clk_pkg holds:
  - CNT_W default
  - DEFAULT_TC (294)
  - state enum (IDLE/RUN/STOPPING)
  - helper constant for the period formula, used by the bench
- Single module. The counter/toggle datapath is small enough that no sub-module is warranted.

Test Plan:
- Reset, then enable=1 with defaults -> first clk_out rise after 295 cycles; period 590, high 295 / low 295; tick=1 once per period, aligned with the rise.
- Load tc_value=3 mid-high-phase with default TC -> upd_pending=1 until the next fall. After that, clk_out period is 8 cycles and tc_active=3; the old half-period is not truncated.
- Two loads (TC=5, then TC=1) within one period -> only TC=1 applied at the boundary; period 4.
- TC=0 -> clk_out toggles every cycle (period 2); tick on every other cycle.
- TC=9: drop enable 3 cycles into the high phase -> clk_out stays high 7 more cycles (10 total), then falls; running=0 the next cycle; no tick afterwards. Repeat with the drop during the low phase -> immediate IDLE with clk_out=0.
- Assert reset mid-run with upd_pending=1 -> next cycle clk_out=0, tick=0, tc_active=294, upd_pending=0.

Source files
------------

// File: rtl/vfd_clk_pkg.sv
// Shared definitions for the programmable VFD clock divider.
//   VFD_CNT_W       default width of the counter and terminal-count registers
//   VFD_DEFAULT_TC  terminal count in effect after reset (590-cycle period)
//   clk_state_e     divider run-control states
//   period_cycles() full clk_out period, in clk_in cycles, for a given TC
package vfd_clk_pkg;

  localparam int VFD_CNT_W      = 16;
  localparam int VFD_DEFAULT_TC = 294;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } clk_state_e;

  // Each half-period lasts TC+1 cycles.
  function automatic int unsigned period_cycles(input int unsigned tc);
    return 2 * (tc + 1);
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider for the VFD timing chain.
// clk_out period is 2*(tc_active+1) clk_in cycles. New terminal counts are
// held pending and only take effect where clk_out falls, and stopping
// always lets a high phase finish, so clk_out never produces a runt pulse.
//
// Ports:
//   clk_in       system clock (all logic on its rising edge)
//   reset        synchronous, active-high reset
//   enable       run request, level-sensitive
//   tc_load      one-cycle strobe capturing tc_value
//   tc_value     new terminal count (half-period minus 1)
//   clk_out      divided clock, registered
//   tick         one-cycle pulse in the cycle clk_out rises
//   tc_active    terminal count currently in use
//   upd_pending  a loaded value is waiting for a period boundary
//   running      high in RUN or STOPPING
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | counter held at 0, clk_out low, TC loads apply at once
// ST_RUN      | counting; clk_out toggles when counter hits tc_active
// ST_STOPPING | enable dropped during high phase; finishing that phase
module clk_div_prog
  import vfd_clk_pkg::*;
#(
  parameter int CNT_W      = VFD_CNT_W,
  parameter int DEFAULT_TC = VFD_DEFAULT_TC
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             tc_load,
  input  logic [CNT_W-1:0] tc_value,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] tc_active,
  output logic             upd_pending,
  output logic             running
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TC_RESET  = CNT_W'(DEFAULT_TC);

  clk_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] tc_active_q, tc_active_d;
  logic [CNT_W-1:0] tc_pend_q, tc_pend_d;
  logic             upd_pending_q, upd_pending_d;

  logic at_tc;
  logic boundary;

  assign at_tc    = (cnt_q == tc_active_q);
  // clk_out is about to fall: the only point where TC may change or we may stop.
  assign boundary = at_tc && clk_out_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clk_out_d     = clk_out_q;
    tick_d        = 1'b0;
    tc_active_d   = tc_active_q;
    tc_pend_d     = tc_pend_q;
    upd_pending_d = upd_pending_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = CNT_ZERO;
        clk_out_d = 1'b0;
        // clk_out is parked low, so a new TC can be adopted immediately.
        // A value left pending by a low-phase stop is also flushed here.
        if (tc_load) begin
          tc_active_d   = tc_value;
          upd_pending_d = 1'b0;
        end else if (upd_pending_q) begin
          tc_active_d   = tc_pend_q;
          upd_pending_d = 1'b0;
        end
        if (enable) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (at_tc) begin
          cnt_d     = CNT_ZERO;
          clk_out_d = ~clk_out_q;
          tick_d    = ~clk_out_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end

        // Apply the old pending value first; a load in the same cycle
        // must wait for the following boundary.
        if (boundary && upd_pending_q) begin
          tc_active_d   = tc_pend_q;
          upd_pending_d = 1'b0;
        end
        if (tc_load) begin
          tc_pend_d     = tc_value;
          upd_pending_d = 1'b1;
        end

        if (enable) begin
          state_d = ST_RUN;
        end else if (!clk_out_q) begin
          state_d   = ST_IDLE;
          cnt_d     = CNT_ZERO;
          clk_out_d = 1'b0;
          tick_d    = 1'b0;
        end else if (boundary) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOPPING;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = CNT_ZERO;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      tc_active_q   <= TC_RESET;
      tc_pend_q     <= CNT_ZERO;
      upd_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      tc_active_q   <= tc_active_d;
      tc_pend_q     <= tc_pend_d;
      upd_pending_q <= upd_pending_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign tc_active   = tc_active_q;
  assign upd_pending = upd_pending_q;
  assign running     = (state_q != ST_IDLE);

endmodule
